// File: rtl/uart_tx_fifo_if.sv
// Byte-FIFO / transmitter hand-off bundle: producer write port plus the
// launch/done handshake toward the UART transmitter.
interface uart_tx_fifo_if #(
    parameter int ADDR_W = 4
);
    logic              wr_en;
    logic [7:0]        wr_data;
    logic              flush;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic [7:0]        tx_data;
    logic              tx_en;
    logic              tx_done;
    logic              in_flight;

    modport master (
        output wr_en, wr_data, flush, tx_done,
        input  full, empty, count, overflow, tx_data, tx_en, in_flight
    );

    modport slave (
        input  wr_en, wr_data, flush, tx_done,
        output full, empty, count, overflow, tx_data, tx_en, in_flight
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Circular byte buffer feeding a UART transmitter one byte per frame:
// launch with a single-cycle tx_en, then hold until the transmitter's done pulse.
module uart_tx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic           clk,
    input  logic           rst,
    uart_tx_fifo_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ACK  = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_reg;
    logic [ADDR_W-1:0] rd_ptr_reg;
    logic [ADDR_W:0]   count_reg;
    logic [7:0]        tx_data_reg;
    logic              tx_en_reg;
    logic              tx_en_next;
    logic              in_flight_reg;
    logic              in_flight_next;
    logic              overflow_reg;
    state_t            state_reg;
    state_t            state_next;

    logic full;
    logic push;
    logic pop;

    // Full comes from the registered count, so a same-cycle pop never frees a slot for a write.
    assign full = (count_reg == FULL_COUNT);
    assign push = bus.wr_en && !full && !bus.flush;

    always_comb begin
        state_next     = state_reg;
        pop            = 1'b0;
        tx_en_next     = 1'b0;
        in_flight_next = in_flight_reg;
        case (state_reg)
            IDLE: begin
                if (count_reg != '0 && !bus.flush) begin
                    pop            = 1'b1;
                    tx_en_next     = 1'b1;
                    in_flight_next = 1'b1;
                    state_next     = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                state_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (bus.tx_done) begin
                    in_flight_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            tx_en_reg     <= 1'b0;
            in_flight_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            tx_en_reg     <= tx_en_next;
            in_flight_reg <= in_flight_next;
        end
    end

    // Storage array kept free of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr_reg] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            tx_data_reg  <= 8'h00;
            overflow_reg <= 1'b0;
        end else begin
            overflow_reg <= bus.wr_en && full;
            if (bus.flush) begin
                rd_ptr_reg <= wr_ptr_reg;
                count_reg  <= '0;
            end else begin
                if (push) begin
                    wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
                end
                if (pop) begin
                    rd_ptr_reg  <= rd_ptr_reg + ADDR_W'(1);
                    tx_data_reg <= mem[rd_ptr_reg];
                end
                case ({push, pop})
                    2'b10:   count_reg <= count_reg + (ADDR_W + 1)'(1);
                    2'b01:   count_reg <= count_reg - (ADDR_W + 1)'(1);
                    default: count_reg <= count_reg;
                endcase
            end
        end
    end

    assign bus.full      = full;
    assign bus.empty     = (count_reg == '0);
    assign bus.count     = count_reg;
    assign bus.overflow  = overflow_reg;
    assign bus.tx_data   = tx_data_reg;
    assign bus.tx_en     = tx_en_reg;
    assign bus.in_flight = in_flight_reg;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed scenarios plus randomized traffic against a queue-based model of
// the byte FIFO and its one-frame-at-a-time launch behaviour.
module tb_uart_tx_fifo;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_tx_fifo_if #(.ADDR_W(ADDR_W)) bus ();

    uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: queued bytes, transmitter-busy flag, last launched byte.
    logic [7:0] m_q[$];
    bit         m_busy;
    int         m_launch_cyc;
    logic [7:0] m_tx_data;
    bit         m_tx_en;
    bit         m_ovf;
    int         cyc_n = 0;
    bit         auto_done = 0;
    int         done_delay = 20;
    int         last_done_edge = -100;

    // One clock edge: update the model from the inputs seen at the edge, then settle.
    task automatic tick();
        bit full_pre, launch, acc, done_ok;
        if (auto_done)
            bus.tx_done = m_busy && (cyc_n + 1 == m_launch_cyc + done_delay);
        @(posedge clk);
        cyc_n++;
        if (rst) begin
            m_q.delete();
            m_busy    = 0;
            m_tx_data = 8'h00;
            m_tx_en   = 0;
            m_ovf     = 0;
        end else begin
            if (bus.tx_done) last_done_edge = cyc_n;
            full_pre = (m_q.size() == DEPTH);
            done_ok  = m_busy && bus.tx_done && (cyc_n > m_launch_cyc + 1);
            launch   = !m_busy && (m_q.size() != 0) && !bus.flush;
            acc      = bus.wr_en && !full_pre && !bus.flush;
            m_ovf    = bus.wr_en && full_pre;
            m_tx_en  = launch;
            if (bus.flush) begin
                m_q.delete();
            end else begin
                if (launch) begin
                    m_tx_data    = m_q.pop_front();
                    m_busy       = 1;
                    m_launch_cyc = cyc_n;
                end
                if (acc) m_q.push_back(bus.wr_data);
            end
            if (done_ok) m_busy = 0;
        end
        #1;
        if (bus.tx_en) $display("cyc %0d launch tx_data=%02h", cyc_n, bus.tx_data);
    endtask

    task automatic idle_inputs();
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        bus.flush   = 1'b0;
        bus.tx_done = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        auto_done = 0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] b);
        bus.wr_en   = 1'b1;
        bus.wr_data = b;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic pulse_done();
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
    endtask

    task automatic wait_launch(input int budget, output bit seen);
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (bus.tx_en) seen = 1;
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (bus.full !== 1'b0)      begin bad++; $display("FAIL reset_full got=%b exp=0", bus.full); end
        total++; if (bus.empty !== 1'b1)     begin bad++; $display("FAIL reset_empty got=%b exp=1", bus.empty); end
        total++; if (bus.count !== 5'd0)     begin bad++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
        total++; if (bus.overflow !== 1'b0)  begin bad++; $display("FAIL reset_overflow got=%b exp=0", bus.overflow); end
        total++; if (bus.tx_en !== 1'b0)     begin bad++; $display("FAIL reset_tx_en got=%b exp=0", bus.tx_en); end
        total++; if (bus.tx_data !== 8'h00)  begin bad++; $display("FAIL reset_tx_data got=%h exp=00", bus.tx_data); end
        total++; if (bus.in_flight !== 1'b0) begin bad++; $display("FAIL reset_in_flight got=%b exp=0", bus.in_flight); end
    endtask

    task automatic test_single();
        do_reset();
        write_byte(8'hA5);
        total++; if (bus.count !== 5'd1) begin bad++; $display("FAIL single_count_after_write got=%0d exp=1", bus.count); end
        total++; if (bus.tx_en !== 1'b0) begin bad++; $display("FAIL single_tx_en_early got=%b exp=0", bus.tx_en); end
        tick();
        total++; if (bus.tx_en !== 1'b1)     begin bad++; $display("FAIL single_tx_en got=%b exp=1", bus.tx_en); end
        total++; if (bus.tx_data !== 8'hA5)  begin bad++; $display("FAIL single_tx_data got=%h exp=a5", bus.tx_data); end
        total++; if (bus.count !== 5'd0)     begin bad++; $display("FAIL single_count_after_launch got=%0d exp=0", bus.count); end
        total++; if (bus.in_flight !== 1'b1) begin bad++; $display("FAIL single_in_flight got=%b exp=1", bus.in_flight); end
        tick();
        total++; if (bus.tx_en !== 1'b0) begin bad++; $display("FAIL single_tx_en_width got=%b exp=0", bus.tx_en); end
        repeat (5) tick();
        total++; if (bus.in_flight !== 1'b1) begin bad++; $display("FAIL single_in_flight_hold got=%b exp=1", bus.in_flight); end
        pulse_done();
        total++; if (bus.in_flight !== 1'b0) begin bad++; $display("FAIL single_in_flight_clear got=%b exp=0", bus.in_flight); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] seen_data [8];
        int n = 0;
        do_reset();
        auto_done  = 1;
        done_delay = 20;
        for (int i = 0; i < 120; i++) begin
            bus.wr_en   = (i < 3);
            bus.wr_data = 8'(i + 1);
            tick();
            if (bus.tx_en) begin
                if (n > 0) begin
                    total++;
                    if (cyc_n !== last_done_edge + 1) begin
                        bad++; $display("FAIL b2b_gap got_edge=%0d exp_edge=%0d", cyc_n, last_done_edge + 1);
                    end
                end
                if (n < 8) seen_data[n] = bus.tx_data;
                n++;
            end
        end
        bus.wr_en = 1'b0;
        auto_done = 0;
        bus.tx_done = 1'b0;
        total++; if (n !== 3) begin bad++; $display("FAIL b2b_launch_count got=%0d exp=3", n); end
        for (int k = 0; k < 3 && k < n; k++) begin
            total++;
            if (seen_data[k] !== 8'(k + 1)) begin
                bad++; $display("FAIL b2b_order idx=%0d got=%h exp=%h", k, seen_data[k], 8'(k + 1));
            end
        end
        total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL b2b_empty got=%b exp=1", bus.empty); end
    endtask

    task automatic test_fill_overflow();
        logic [7:0] bytes [17];
        bit seen;
        do_reset();
        for (int i = 0; i < 17; i++) begin
            bytes[i] = 8'($urandom);
            write_byte(bytes[i]);
        end
        total++; if (bus.count !== 5'd16) begin bad++; $display("FAIL fill_count got=%0d exp=16", bus.count); end
        total++; if (bus.full !== 1'b1)   begin bad++; $display("FAIL fill_full got=%b exp=1", bus.full); end
        write_byte(8'hEE);
        total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL fill_overflow got=%b exp=1", bus.overflow); end
        total++; if (bus.count !== 5'd16)   begin bad++; $display("FAIL fill_count_after_ovf got=%0d exp=16", bus.count); end
        tick();
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL fill_overflow_width got=%b exp=0", bus.overflow); end
        for (int k = 0; k < 17; k++) begin
            total++;
            if (bus.tx_data !== bytes[k] || bus.in_flight !== 1'b1) begin
                bad++; $display("FAIL fill_order idx=%0d got=%h exp=%h in_flight=%b", k, bus.tx_data, bytes[k], bus.in_flight);
            end
            pulse_done();
            if (k < 16) begin
                wait_launch(5, seen);
                total++;
                if (!seen) begin bad++; $display("FAIL fill_launch_timeout idx=%0d got=none exp=tx_en", k + 1); end
                tick();
            end
        end
        total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL fill_drained_empty got=%b exp=1", bus.empty); end
    endtask

    task automatic test_write_during_pop();
        bit seen;
        do_reset();
        write_byte(8'h11);
        write_byte(8'h22);
        total++; if (bus.count !== 5'd1)    begin bad++; $display("FAIL wdp_count got=%0d exp=1", bus.count); end
        total++; if (bus.tx_data !== 8'h11) begin bad++; $display("FAIL wdp_first got=%h exp=11", bus.tx_data); end
        tick();
        pulse_done();
        wait_launch(5, seen);
        total++;
        if (!seen || bus.tx_data !== 8'h22) begin
            bad++; $display("FAIL wdp_second got=%h seen=%b exp=22", bus.tx_data, seen);
        end
        tick();
        pulse_done();
        total++; if (bus.empty !== 1'b1 || bus.in_flight !== 1'b0) begin
            bad++; $display("FAIL wdp_end got_empty=%b got_in_flight=%b exp=1/0", bus.empty, bus.in_flight);
        end
    endtask

    task automatic test_flush();
        int launches = 0;
        do_reset();
        for (int i = 0; i < 6; i++) write_byte(8'hC0 + 8'(i));
        total++; if (bus.count !== 5'd5) begin bad++; $display("FAIL flush_pre_count got=%0d exp=5", bus.count); end
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        total++; if (bus.count !== 5'd0)     begin bad++; $display("FAIL flush_count got=%0d exp=0", bus.count); end
        total++; if (bus.empty !== 1'b1)     begin bad++; $display("FAIL flush_empty got=%b exp=1", bus.empty); end
        total++; if (bus.in_flight !== 1'b1) begin bad++; $display("FAIL flush_in_flight got=%b exp=1", bus.in_flight); end
        total++; if (bus.tx_data !== 8'hC0)  begin bad++; $display("FAIL flush_tx_data got=%h exp=c0", bus.tx_data); end
        repeat (3) tick();
        pulse_done();
        total++; if (bus.in_flight !== 1'b0) begin bad++; $display("FAIL flush_done got=%b exp=0", bus.in_flight); end
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.tx_en) launches++;
        end
        total++; if (launches !== 0) begin bad++; $display("FAIL flush_no_launch got=%0d exp=0", launches); end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        for (int i = 0; i < 5; i++) write_byte(8'h30 + 8'(i));
        tick();
        total++; if (bus.count !== 5'd4 || bus.in_flight !== 1'b1) begin
            bad++; $display("FAIL rstmid_pre got_count=%0d got_in_flight=%b exp=4/1", bus.count, bus.in_flight);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (bus.count !== 5'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.overflow !== 1'b0 ||
            bus.tx_en !== 1'b0 || bus.tx_data !== 8'h00 || bus.in_flight !== 1'b0) begin
            bad++; $display("FAIL rstmid_outputs got count=%0d empty=%b full=%b ovf=%b tx_en=%b tx_data=%h in_flight=%b exp 0/1/0/0/0/00/0",
                bus.count, bus.empty, bus.full, bus.overflow, bus.tx_en, bus.tx_data, bus.in_flight);
        end
        write_byte(8'h5A);
        total++; if (bus.tx_en !== 1'b0) begin bad++; $display("FAIL rstmid_early got=%b exp=0", bus.tx_en); end
        tick();
        total++; if (bus.tx_en !== 1'b1 || bus.tx_data !== 8'h5A) begin
            bad++; $display("FAIL rstmid_relaunch got_tx_en=%b got_data=%h exp=1/5a", bus.tx_en, bus.tx_data);
        end
        tick();
        pulse_done();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bus.wr_en   = ($urandom_range(0, 99) < 45);
            bus.wr_data = 8'($urandom);
            bus.flush   = ($urandom_range(0, 59) == 0);
            bus.tx_done = ($urandom_range(0, 4) == 0);
            rst         = ($urandom_range(0, 599) == 0);
            tick();
            total++;
            if (bus.count !== (ADDR_W + 1)'(m_q.size()) || bus.count > DEPTH) begin
                bad++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", cyc_n, bus.count, m_q.size());
            end
            total++;
            if (bus.full !== (m_q.size() == DEPTH) || bus.empty !== (m_q.size() == 0)) begin
                bad++; $display("FAIL rnd_flags cyc=%0d got_full=%b got_empty=%b exp_size=%0d", cyc_n, bus.full, bus.empty, m_q.size());
            end
            total++;
            if (bus.overflow !== m_ovf) begin
                bad++; $display("FAIL rnd_overflow cyc=%0d got=%b exp=%b", cyc_n, bus.overflow, m_ovf);
            end
            total++;
            if (bus.tx_en !== m_tx_en || bus.tx_data !== m_tx_data) begin
                bad++; $display("FAIL rnd_launch cyc=%0d got_en=%b got_data=%h exp_en=%b exp_data=%h", cyc_n, bus.tx_en, bus.tx_data, m_tx_en, m_tx_data);
            end
            total++;
            if (bus.in_flight !== m_busy) begin
                bad++; $display("FAIL rnd_in_flight cyc=%0d got=%b exp=%b", cyc_n, bus.in_flight, m_busy);
            end
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single();
        test_back_to_back();
        test_fill_overflow();
        test_write_during_pop();
        test_flush();
        test_reset_mid_frame();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte FIFO and launch controller sitting directly upstream of the UART transmitter.
- Accepts bytes from a producer (CPU/test logic or the RX loopback path) on a valid-only write port and buffers them.
- Presents one byte at a time to the transmitter with a one-cycle tx_en pulse.
- Holds off the next byte until the transmitter's done pulse, so back-to-back frames go out with no lost or duplicated bytes.

Parameters:
DEPTH, 16, number of byte entries; power of two, 2..256
ADDR_W, 4, log2(DEPTH); pointer width

Ports:
clk  input  1  system clock (100 MHz)
rst  input  1  reset, synchronous, active-high
wr_en  input  1  write strobe; byte accepted on a rising edge when wr_en=1 and full=0
wr_data  input  8  byte to enqueue
flush  input  1  synchronous clear of queued (not yet launched) bytes
full  output  1  count==DEPTH
empty  output  1  count==0
count  output  ADDR_W+1  number of queued bytes (excludes the byte in flight)
overflow  output  1  one-cycle pulse: write attempted while full, byte dropped
tx_data  output  8  byte to transmitter d_in; registered, stable from launch until the next launch
tx_en  output  1  one-cycle launch pulse to transmitter
tx_done  input  1  one-cycle completion pulse from transmitter
in_flight  output  1  high from launch edge until tx_done is sampled

Behaviour:
- Reset (rst=1 at an edge):
  - Pointers and count go to 0; state goes to IDLE.
  - Outputs: full=0, empty=1, overflow=0, tx_en=0, tx_data=8'h00, in_flight=0.
  - Memory contents are not cleared.
  - Reset mid-frame simply abandons the frame; the transmitter receives its own reset.
- Storage: circular buffer of DEPTH x 8.
  - wr_ptr and rd_ptr are ADDR_W bits and wrap naturally from DEPTH-1 to 0.
  - count is a separate ADDR_W+1 bit register.
- Write: accepted at an edge iff wr_en=1 and full=0 (full taken from the registered count).
  - On acceptance: mem[wr_ptr]<=wr_data, wr_ptr+1, count+1.
  - Write while full: byte dropped, no pointer change, overflow=1 for exactly the next cycle.
  - Full is not relieved by a same-cycle pop: a write in a cycle where full=1 is always dropped.
- Pop and write in the same cycle: count unchanged, both pointers advance.
- Controller FSM, 3 states:
  - IDLE:
    - If count!=0: tx_data<=mem[rd_ptr], rd_ptr+1, count-1, tx_en<=1, in_flight<=1, go to WAIT_ACK.
    - Otherwise stay, tx_en=0.
  - WAIT_ACK: tx_en<=0 (pulse is exactly 1 cycle wide), go to WAIT_DONE.
  - WAIT_DONE: on tx_done=1, in_flight<=0, go to IDLE; otherwise hold, tx_data unchanged.
  - A tx_done arriving in IDLE or WAIT_ACK is ignored.
- Latency:
  - Write into an empty FIFO with the FSM in IDLE: tx_en is high in the cycle after the following edge, i.e. write at edge N, tx_en sampled high at edge N+2.
  - Minimum gap from tx_done sampled to the next tx_en high is 1 cycle (the IDLE cycle).
- Throughput: one byte per transmitter frame; the transmitter's ~10 baud periods dominate.
- tx_data is registered on the same edge that raises tx_en, so it is stable at the edge where the transmitter samples tx_en.
- flush:
  - Sets rd_ptr<=wr_ptr and count<=0 on that edge; a simultaneous write is dropped.
  - Does not affect an in-flight byte, the FSM state, tx_data or tx_en.
  - Flush takes priority over both the write and the pop in that cycle. If flush coincides with the IDLE pop decision, no launch occurs.
- flush and rst both high: rst wins.
- count never exceeds DEPTH and never underflows; the verification bench asserts this.

Test Plan:
- Reset then a single write of 8'hA5 at edge N -> count=1 after N; tx_en=1 only at edge N+2 with tx_data=8'hA5; count=0; in_flight=1 until tx_done pulse.
- Write 3 bytes 8'h01,8'h02,8'h03 back-to-back; bench tx_done model 20 cycles after each tx_en -> exactly 3 tx_en pulses in order 01,02,03; each launch is 1 cycle after the preceding tx_done; empty=1 at end.
- Hold tx_done low, write 17 bytes (DEPTH=16) -> first byte launched; next 16 fill, full=1, count=16; 18th write gives one overflow pulse and count stays 16; after 16 tx_done pulses the order is preserved with wrap-around of wr_ptr/rd_ptr.
- Write during pop cycle (count=1, FSM in IDLE, wr_en=1) -> count stays 1; both bytes are eventually transmitted in order.
- flush with 5 queued and 1 in flight -> count=0 and empty=1 next cycle; the in-flight byte still completes on tx_done; no further tx_en pulses.
- rst asserted in WAIT_DONE with 4 queued -> all outputs return to reset values next cycle; a subsequent write of 8'h5A is launched normally.
